gcd_binary_unit: RTL and testbench

Parametrised multi-cycle greatest-common-divisor engine using the binary (Stein) algorithm: shifts and one subtractor, no divider or comparator chain per bit. Supersedes the fixed 16-bit subtract-only GCD block. Adds:
- a generic operand width;
- a bounded, data-dependent latency;
- defined zero-operand results;
- a busy/done handshake.

It sits beside other start/done arithmetic units on the datapath and is driven by a control FSM.

---
 rtl/gcd_pkg.sv | 21 ++
 rtl/gcd_stein_step.sv | 50 +++++
 rtl/gcd_binary_unit.sv | 115 +++++++++++
 tb/tb_gcd_binary_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and width helpers for the binary (Stein) GCD unit.
// Optional feature macro: GCD_ITER_CNT_EN (see gcd_binary_unit).
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } gcd_state_e;

    // k counts common factors of two; it never exceeds width-1.
    function automatic int gcd_k_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Step count is bounded by 2*width, so this width never saturates.
    function automatic int gcd_iter_width(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational Stein reduction step plus the termination flag.
// Operands pass through unchanged once either of them is zero.
module gcd_stein_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int KW    = gcd_k_width(WIDTH)
) (
    input  logic [WIDTH-1:0] u_i,
    input  logic [WIDTH-1:0] v_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] u_o,
    output logic [WIDTH-1:0] v_o,
    output logic [KW-1:0]    k_o,
    output logic             term_o
);

    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] diff_lo;
    logic [WIDTH-1:0] diff_neg;

    assign term_o = (u_i == '0) || (v_i == '0);

    // The single subtractor's borrow doubles as the u>=v decision; v-u is its negation.
    assign diff     = {1'b0, u_i} - {1'b0, v_i};
    assign diff_lo  = diff[WIDTH-1:0];
    assign diff_neg = '0 - diff_lo;

    always_comb begin
        u_o = u_i;
        v_o = v_i;
        k_o = k_i;
        if (!term_o) begin
            if (!u_i[0] && !v_i[0]) begin
                u_o = u_i >> 1;
                v_o = v_i >> 1;
                k_o = k_i + 1'b1;
            end else if (!u_i[0]) begin
                u_o = u_i >> 1;
            end else if (!v_i[0]) begin
                v_o = v_i >> 1;
            end else if (!diff[WIDTH]) begin
                u_o = diff_lo >> 1;
            end else begin
                v_o = diff_neg >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_binary_unit.sv
// Multi-cycle binary GCD engine: registers, FSM and start/busy/done handshake.
// Define GCD_ITER_CNT_EN to add the iter_cnt output (REDUCE steps of the last result).
module gcd_binary_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [gcd_iter_width(WIDTH)-1:0] iter_cnt
`endif
);

    localparam int KW = gcd_k_width(WIDTH);

    // Handshake: start is sampled only in IDLE; the sampling edge captures a/b and
    // raises busy. done pulses for one cycle with gcd valid, busy drops one edge
    // later together with done, and gcd holds until the next result is written.
    gcd_state_e       state_q;
    logic [WIDTH-1:0] u_q, v_q, u_d, v_d;
    logic [KW-1:0]    k_q, k_d;
    logic             term;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] gcd_q;

    gcd_stein_step #(
        .WIDTH(WIDTH),
        .KW   (KW)
    ) u_step (
        .u_i   (u_q),
        .v_i   (v_q),
        .k_i   (k_q),
        .u_o   (u_d),
        .v_o   (v_d),
        .k_o   (k_d),
        .term_o(term)
    );

`ifdef GCD_ITER_CNT_EN
    localparam int ITW = gcd_iter_width(WIDTH);
    logic [ITW-1:0] iter_q, iter_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_q     <= '0;
            iter_cnt_q <= '0;
        end else if (state_q == IDLE && start) begin
            iter_q <= '0;
        end else if (state_q == REDUCE) begin
            if (term) iter_cnt_q <= iter_q;
            else      iter_q     <= iter_q + 1'b1;
        end
    end

    assign iter_cnt = iter_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            u_q     <= '0;
            v_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gcd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        u_q     <= a;
                        v_q     <= b;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (term) begin
                        // One operand is zero, so the OR is the surviving odd part.
                        gcd_q   <= (u_q | v_q) << k_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        u_q <= u_d;
                        v_q <= v_d;
                        k_q <= k_d;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gcd  = gcd_q;

endmodule

// File: tb/tb_gcd_binary_unit.sv
// Self-checking bench for gcd_binary_unit (WIDTH=16) against a Euclid reference.
// Define GCD_ITER_CNT_EN for both bench and RTL to also check iter_cnt.
module tb_gcd_binary_unit;

    localparam int W       = 16;
    localparam int MAX_LAT = 2 * W + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] gcd;
`ifdef GCD_ITER_CNT_EN
    logic [$clog2(2*W+1)-1:0] iter_cnt;
`endif

    int checks;
    int errors;
    logic [W-1:0] exp_q[$];

    gcd_binary_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .gcd  (gcd)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt(iter_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p[W-1:0];
    endfunction

    // ---------------- driver ----------------
    // Runs one operation; lat = edges from accept to done visible, -1 on timeout.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          output logic [W-1:0] got, output int lat,
                          output bit busy0, output bit held_ok, output bit post_ok);
        logic [W-1:0] snap;
        got     = '0;
        lat     = -1;
        held_ok = 1'b1;
        post_ok = 1'b0;
        @(negedge clk);
        snap  = gcd;
        start = 1'b1;
        a     = oa;
        b     = ob;
        @(posedge clk);
        #1;
        busy0 = busy;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        for (int n = 1; n <= MAX_LAT + 4; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                got = gcd;
                break;
            end
            if (gcd !== snap) held_ok = 1'b0;
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            post_ok = (done === 1'b0) && (busy === 1'b0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'd12;
        b     = 16'd8;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_ctrl: busy=%b done=%b, required busy=0 done=0", busy, done);
        end
        checks++;
        if (gcd !== '0) begin
            errors++;
            $display("FAIL reset_hold_gcd: gcd=%0d, required 0", gcd);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || gcd !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b gcd=%0d, required 0/0/0", busy, done, gcd);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] ta[6] = '{16'd48, 16'd7, 16'd0, 16'd0,  16'd40, 16'hFFFF};
        logic [W-1:0] tb[6] = '{16'd18, 16'd7, 16'd0, 16'd40, 16'd0,  16'h8000};
        logic [W-1:0] tg[6] = '{16'd6,  16'd7, 16'd0, 16'd40, 16'd40, 16'd1};
        int           tl[6] = '{7, 2, 1, 1, 1, 0};
        logic [W-1:0] got;
        int  lat;
        bit  busy0, held_ok, post_ok;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], got, lat, busy0, held_ok, post_ok);
            checks++;
            if (got !== tg[i]) begin
                errors++;
                $display("FAIL dir_gcd[%0d]: gcd(%0d,%0d)=%0d, required %0d", i, ta[i], tb[i], got, tg[i]);
            end
            checks++;
            if ((tl[i] != 0 && lat != tl[i]) || lat < 1 || lat > MAX_LAT) begin
                errors++;
                $display("FAIL dir_lat[%0d]: latency=%0d, required %0d (bound %0d)", i, lat, tl[i], MAX_LAT);
            end
            checks++;
            if (!busy0 || !held_ok || !post_ok) begin
                errors++;
                $display("FAIL dir_hs[%0d]: busy_after_accept=%0b gcd_held=%0b idle_after=%0b, required 1/1/1",
                         i, busy0, held_ok, post_ok);
            end
`ifdef GCD_ITER_CNT_EN
            if (i == 0) begin
                checks++;
                if (iter_cnt !== 6) begin
                    errors++;
                    $display("FAIL dir_iter_cnt: iter_cnt=%0d, required 6", iter_cnt);
                end
            end
`endif
        end
    endtask

    task automatic test_random(input int n_ops);
        logic [W-1:0] oa, ob, got, expv;
        int  lat, sel, bad;
        bit  busy0, held_ok, post_ok;
        bad = 0;
        for (int i = 0; i < n_ops; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                oa = W'($urandom);
                ob = W'($urandom);
            end else if (sel < 8) begin
                int unsigned g;
                g  = 1 << $urandom_range(0, 7);
                oa = W'($urandom_range(0, 255) * g);
                ob = W'($urandom_range(0, 255) * g);
            end else begin
                oa = (sel == 8) ? '0 : W'($urandom);
                ob = (sel == 9) ? '0 : W'($urandom_range(0, 3));
            end
            exp_q.push_back(ref_gcd(oa, ob));
            run_op(oa, ob, got, lat, busy0, held_ok, post_ok);
            expv = exp_q.pop_front();
            checks++;
            if (got !== expv || lat < 1 || lat > MAX_LAT || !busy0 || !post_ok) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rand[%0d]: gcd(%0d,%0d)=%0d lat=%0d busy=%0b idle=%0b, required %0d lat<=%0d 1 1",
                             i, oa, ob, got, lat, busy0, post_ok, expv, MAX_LAT);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] cur_a, cur_b, expv;
        int  next_accept, gap_edge, n_done;
        bit  timed_out;
        next_accept = 0;
        gap_edge    = -1;
        n_done      = 0;
        timed_out   = 1'b1;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            start = 1'b1;
            cur_a = W'($urandom_range(1, 60) * $urandom_range(1, 8));
            cur_b = W'($urandom_range(1, 60) * $urandom_range(1, 8));
            a     = cur_a;
            b     = cur_b;
            @(posedge clk);
            #1;
            if (cyc == gap_edge) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap@%0d: busy=%b done=%b, required 0/0", cyc, busy, done);
                end
            end
            if (cyc == next_accept) begin
                exp_q.push_back(ref_gcd(cur_a, cur_b));
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_accept@%0d: busy=%b, required 1", cyc, busy);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_done@%0d: done=1, required 0", cyc);
                end else begin
                    expv = exp_q.pop_front();
                    if (gcd !== expv) begin
                        errors++;
                        $display("FAIL b2b_gcd[%0d]: gcd=%0d, required %0d", n_done, gcd, expv);
                    end
                end
                n_done++;
                gap_edge    = cyc + 1;
                next_accept = cyc + 2;
                if (n_done == 5) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (MAX_LAT + 3) @(posedge clk);
        #1;
        checks++;
        if (timed_out || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: timed_out=%0b busy=%b, required 0/0", timed_out, busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] got;
        int  lat, seen_done;
        bit  busy0, held_ok, post_ok;
        @(negedge clk);
        start = 1'b1;
        a     = 16'd1000;
        b     = 16'd250;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || gcd !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: busy=%b done=%b gcd=%0d, required 0/0/0", busy, done, gcd);
        end
        seen_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) seen_done++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (MAX_LAT) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0 || gcd !== '0) begin
            errors++;
            $display("FAIL rst_mid_quiet: activity_cycles=%0d gcd=%0d, required 0/0", seen_done, gcd);
        end
        run_op(16'd9, 16'd6, got, lat, busy0, held_ok, post_ok);
        checks++;
        if (got !== 16'd3 || lat < 1 || lat > MAX_LAT) begin
            errors++;
            $display("FAIL rst_mid_restart: gcd=%0d lat=%0d, required 3 lat<=%0d", got, lat, MAX_LAT);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        rst    = 1'b1;
        test_reset();
        test_directed();
        test_random(1500);
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
